// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing_generator to its downstream consumers.
// The master drives the position and strobes. Consumers attach through the slave modport.
interface vga_timing_if;
  logic [10:0] x;
  logic [9:0]  y;
  logic        active;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output x, y, active, hsync, vsync, line_start, frame_start, frame_count
  );

  modport slave (
    input  x, y, active, hsync, vsync, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_generator.sv
// Pixel-clock raster generator: position counters plus registered sync/active/strobe outputs.
// Optional frame counter is enabled by defining VGA_TIMING_FRAME_COUNTER_EN.
module vga_timing_generator #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        line_end, frame_end;
  logic        active_q, active_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  // Outputs are decoded from the next position so every flop describes the same (x,y).
  always_comb begin
    line_end      = (h_q == H_LAST);
    frame_end     = line_end && (v_q == V_LAST);
    h_d           = line_end ? 11'd0 : h_q + 11'd1;
    v_d           = frame_end ? 10'd0 : (line_end ? v_q + 10'd1 : v_q);
    active_d      = (h_d < H_ACT_END) && (v_d < V_ACT_END);
    hsync_d       = ((h_d >= HS_START) && (h_d < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d       = ((v_d >= VS_START) && (v_d < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    line_start_d  = (h_d == 11'd0);
    frame_start_d = (h_d == 11'd0) && (v_d == 10'd0);
  end

  // Position (0,0) is never inside a porch or sync window since every width is at least 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= 11'd0;
      v_q           <= 10'd0;
      active_q      <= 1'b1;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_COUNTER_EN
  logic [15:0] frame_cnt_q;

  // Counts only the natural wrap; the reset-loaded origin is excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
    end else if (frame_end) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vga.frame_count = frame_cnt_q;
`else
  assign vga.frame_count = 16'd0;
`endif

  assign vga.x           = h_q;
  assign vga.y           = v_q;
  assign vga.active      = active_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: default 640x480 timing for the first line, a reduced raster with
// inverted sync polarity for whole-frame, mid-frame reset and frame counter checks.
module tb_vga_timing_generator;
  logic clk = 1'b0;
  logic rst_d;
  logic rst_s;

  always #5 clk = ~clk;

  vga_timing_if d_if();
  vga_timing_if s_if();

  vga_timing_generator dut_def (
    .clk   (clk),
    .reset (rst_d),
    .vga   (d_if)
  );

  // Reduced raster: H_TOTAL=15 (hsync x=10..12), V_TOTAL=8 (vsync y=5..6), 120 clocks per frame.
  vga_timing_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_sm (
    .clk   (clk),
    .reset (rst_s),
    .vga   (s_if)
  );

  int          total = 0;
  int          bad   = 0;
  int          px, py;
  int          fs_pulses;
  int          hs_low;
  logic [15:0] m_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance the reduced-raster reference by one clock and compare every output.
  task automatic sm_step();
    tick();
    px++;
    if (px == 15) begin
      px = 0;
      py++;
      if (py == 8) begin
        py = 0;
`ifdef VGA_TIMING_FRAME_COUNTER_EN
        m_fc = m_fc + 16'd1;
`endif
      end
    end
    if (s_if.frame_start === 1'b1) fs_pulses++;
    chk("sm_x",      32'(s_if.x),           32'(px));
    chk("sm_y",      32'(s_if.y),           32'(py));
    chk("sm_active", 32'(s_if.active),      32'(px < 8 && py < 4));
    chk("sm_hsync",  32'(s_if.hsync),       32'(px >= 10 && px < 13));
    chk("sm_vsync",  32'(s_if.vsync),       32'(py >= 5 && py < 7));
    chk("sm_lstart", 32'(s_if.line_start),  32'(px == 0));
    chk("sm_fstart", 32'(s_if.frame_start), 32'(px == 0 && py == 0));
    chk("sm_fcount", 32'(s_if.frame_count), 32'(m_fc));
  endtask

  initial begin
    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (3) tick();

    chk("def_rst_x",      32'(d_if.x),           32'd0);
    chk("def_rst_y",      32'(d_if.y),           32'd0);
    chk("def_rst_active", 32'(d_if.active),      32'd1);
    chk("def_rst_hsync",  32'(d_if.hsync),       32'd1);
    chk("def_rst_vsync",  32'(d_if.vsync),       32'd1);
    chk("def_rst_lstart", 32'(d_if.line_start),  32'd1);
    chk("def_rst_fstart", 32'(d_if.frame_start), 32'd1);
    chk("def_rst_fcount", 32'(d_if.frame_count), 32'd0);
    chk("sm_rst_hsync",   32'(s_if.hsync),       32'd0);
    chk("sm_rst_vsync",   32'(s_if.vsync),       32'd0);
    chk("sm_rst_fstart",  32'(s_if.frame_start), 32'd1);

    // Default timing: first line after release.
    rst_d = 1'b0;
    tick();
    chk("def_rel_x",      32'(d_if.x),           32'd1);
    chk("def_rel_y",      32'(d_if.y),           32'd0);
    chk("def_rel_fstart", 32'(d_if.frame_start), 32'd0);
    chk("def_rel_lstart", 32'(d_if.line_start),  32'd0);
    chk("def_rel_active", 32'(d_if.active),      32'd1);
    hs_low = 0;
    for (int i = 2; i < 800; i++) begin
      tick();
      if (d_if.hsync === 1'b0) hs_low++;
      if (i == 639) chk("def_act_639", 32'(d_if.active), 32'd1);
      if (i == 640) chk("def_act_640", 32'(d_if.active), 32'd0);
      if (i == 655) chk("def_hs_655",  32'(d_if.hsync),  32'd1);
      if (i == 656) chk("def_hs_656",  32'(d_if.hsync),  32'd0);
      if (i == 751) chk("def_hs_751",  32'(d_if.hsync),  32'd0);
      if (i == 752) chk("def_hs_752",  32'(d_if.hsync),  32'd1);
      if (i == 799) chk("def_x_799",   32'(d_if.x),      32'd799);
    end
    chk("def_hs_width", 32'(hs_low), 32'd96);
    tick();
    chk("def_l1_x",      32'(d_if.x),           32'd0);
    chk("def_l1_y",      32'(d_if.y),           32'd1);
    chk("def_l1_lstart", 32'(d_if.line_start),  32'd1);
    chk("def_l1_fstart", 32'(d_if.frame_start), 32'd0);
    chk("def_l1_active", 32'(d_if.active),      32'd1);
    chk("def_l1_vsync",  32'(d_if.vsync),       32'd1);

    // Reduced raster: three full frames from release.
    rst_s = 1'b0;
    px = 0;
    py = 0;
    m_fc = 16'd0;
    fs_pulses = 0;
    repeat (360) sm_step();
    chk("sm_fs_pulses", 32'(fs_pulses), 32'd3);
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    chk("sm_fc_3frames", 32'(s_if.frame_count), 32'd3);
`else
    chk("sm_fc_3frames", 32'(s_if.frame_count), 32'd0);
`endif

    // Mid-frame reset at (6,2).
    for (int n = 0; n < 130 && !(px == 6 && py == 2); n++) sm_step();
    chk("sm_pre_rst_x", 32'(s_if.x), 32'd6);
    rst_s = 1'b1;
    tick();
    px = 0;
    py = 0;
    m_fc = 16'd0;
    chk("sm_mrst_x",      32'(s_if.x),           32'd0);
    chk("sm_mrst_y",      32'(s_if.y),           32'd0);
    chk("sm_mrst_fstart", 32'(s_if.frame_start), 32'd1);
    chk("sm_mrst_fcount", 32'(s_if.frame_count), 32'd0);
    chk("sm_mrst_active", 32'(s_if.active),      32'd1);
    chk("sm_mrst_hsync",  32'(s_if.hsync),       32'd0);
    tick();
    chk("sm_mrst_hold_x", 32'(s_if.x), 32'd0);
    rst_s = 1'b0;
    repeat (130) sm_step();

`ifdef VGA_TIMING_FRAME_COUNTER_EN
    // Preload the counter at its maximum and check the wrap at the next frame start.
    for (int n = 0; n < 130 && !(px == 5 && py == 3); n++) sm_step();
    force dut_sm.frame_cnt_q = 16'hFFFF;
    m_fc = 16'hFFFF;
    sm_step();
    release dut_sm.frame_cnt_q;
    repeat (120) sm_step();
    chk("sm_fc_wrap", 32'(s_if.frame_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
